// File: rtl/distribute_tree_multicast_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : distribute_tree_multicast_scheduler_if
// Description : Packet-in / beat-out handshake bundle for the multicast
//               scheduler that feeds a 1x2 distribute switch tree.
// Revision    : 1.0 - initial release
// ============================================================================
interface distribute_tree_multicast_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DEST   = 8
);
  localparam int CMD_W = $clog2(NUM_DEST);

  // Upstream packet side
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data_bus;
  logic [NUM_DEST-1:0]   i_dest_mask;
  logic                  o_ready;

  // Downstream beat side (toward the root switch)
  logic                  o_valid;
  logic                  o_en;
  logic [DATA_WIDTH-1:0] o_data_bus;
  logic [CMD_W-1:0]      o_cmd;
  logic                  o_last;
  logic                  i_ready;

  // Status
  logic                  o_busy;

  // Environment view: drives packets and beat acceptance
  modport master (
    output i_valid, i_data_bus, i_dest_mask, i_ready,
    input  o_ready, o_valid, o_en, o_data_bus, o_cmd, o_last, o_busy
  );

  // Scheduler view
  modport slave (
    input  i_valid, i_data_bus, i_dest_mask, i_ready,
    output o_ready, o_valid, o_en, o_data_bus, o_cmd, o_last, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/distribute_tree_multicast_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : distribute_tree_multicast_scheduler
// Description : Latches one packet with a destination bitmask and serialises
//               it into one unicast beat per set bit, lowest index first,
//               with the binary leaf index as the tree command (MSB = root).
// Revision    : 1.0 - initial release
// ============================================================================
module distribute_tree_multicast_scheduler #(
  parameter int DATA_WIDTH            = 32,
  parameter int NUM_DEST              = 8,
  parameter int DESTINATION_TAG_WIDTH = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  distribute_tree_multicast_scheduler_if.slave bus
);

  localparam int COMMAND_WIDTH = $clog2(NUM_DEST) * DESTINATION_TAG_WIDTH;
  localparam logic [NUM_DEST-1:0] MASK_ONE = {{(NUM_DEST-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_DEST-1:0]      mask_q,  mask_d;
  logic [DATA_WIDTH-1:0]    data_q,  data_d;
  logic                     valid_q, valid_d;
  logic [COMMAND_WIDTH-1:0] cmd_q,   cmd_d;
  logic                     last_q,  last_d;
  logic                     ready_w;

  // Index of the lowest set bit; zero for an empty mask
  function automatic logic [COMMAND_WIDTH-1:0] lowest_index(input logic [NUM_DEST-1:0] m);
    logic [COMMAND_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_DEST - 1; i >= 0; i--) begin
      if (m[i]) idx = COMMAND_WIDTH'(i);
    end
    return idx;
  endfunction

  // Mask with its lowest set bit removed
  function automatic logic [NUM_DEST-1:0] clear_lowest(input logic [NUM_DEST-1:0] m);
    return m & (m - MASK_ONE);
  endfunction

  // Ready only in IDLE and never during reset; independent of i_ready
  assign ready_w = (state_q == IDLE) && !rst;

  // Next-state and beat generation
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // A zero mask is accepted and dropped without leaving IDLE
        if (ready_w && bus.i_valid && (bus.i_dest_mask != '0)) begin
          data_d  = bus.i_data_bus;
          cmd_d   = lowest_index(bus.i_dest_mask);
          mask_d  = clear_lowest(bus.i_dest_mask);
          last_d  = (clear_lowest(bus.i_dest_mask) == '0);
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (valid_q && bus.i_ready) begin
          if (last_q) begin
            // Dummy-data convention: idle beat slot carries zeros
            data_d  = '0;
            cmd_d   = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            mask_d  = '0;
            state_d = IDLE;
          end else begin
            cmd_d  = lowest_index(mask_q);
            mask_d = clear_lowest(mask_q);
            last_d = (clear_lowest(mask_q) == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any remaining destinations
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cmd_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_ready    = ready_w;
  assign bus.o_valid    = valid_q;
  assign bus.o_en       = valid_q;
  assign bus.o_data_bus = data_q;
  assign bus.o_cmd      = cmd_q;
  assign bus.o_last     = last_q;
  assign bus.o_busy     = (state_q == ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_distribute_tree_multicast_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_distribute_tree_multicast_scheduler
// Description : Directed and randomized bench for the multicast scheduler;
//               expected beats are the ascending list of set mask bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distribute_tree_multicast_scheduler;

  localparam int DW = 32;
  localparam int ND = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  distribute_tree_multicast_scheduler_if #(.DATA_WIDTH(DW), .NUM_DEST(ND)) bus ();

  distribute_tree_multicast_scheduler #(
    .DATA_WIDTH(DW), .NUM_DEST(ND), .DESTINATION_TAG_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    chk({tag, "_en"},    64'(bus.o_en), 64'd0);
    chk({tag, "_cmd"},   64'(bus.o_cmd), 64'd0);
    chk({tag, "_data"},  64'(bus.o_data_bus), 64'd0);
    chk({tag, "_last"},  64'(bus.o_last), 64'd0);
    chk({tag, "_busy"},  64'(bus.o_busy), 64'd0);
  endtask

  // Reference: leaves listed in ascending order, one beat each
  task automatic build_expected(input logic [ND-1:0] mask, output int q[$]);
    q = {};
    for (int d = 0; d < ND; d++) if (mask[d]) q.push_back(d);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall first 3 cycles
  task automatic run_packet(input logic [DW-1:0] data, input logic [ND-1:0] mask, input int mode);
    int   exp_q[$];
    int   cyc;
    logic rdy;
    build_expected(mask, exp_q);
    chk("pre_ready", 64'(bus.o_ready), 64'd1);
    chk("pre_busy",  64'(bus.o_busy), 64'd0);
    bus.i_valid     = 1'b1;
    bus.i_data_bus  = data;
    bus.i_dest_mask = mask;
    @(negedge clk);
    bus.i_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc >= 200) begin
        chk("beat_timeout_left", 64'(exp_q.size()), 64'd0);
        break;
      end
      chk("beat_valid", 64'(bus.o_valid), 64'd1);
      chk("beat_en",    64'(bus.o_en), 64'd1);
      chk("beat_cmd",   64'(bus.o_cmd), 64'(exp_q[0]));
      chk("beat_last",  64'(bus.o_last), 64'(exp_q.size() == 1));
      chk("beat_data",  64'(bus.o_data_bus), 64'(data));
      chk("beat_ready", 64'(bus.o_ready), 64'd0);
      chk("beat_busy",  64'(bus.o_busy), 64'd1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (cyc >= 3);
      endcase
      bus.i_ready = rdy;
      @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    bus.i_ready = 1'b1;
    chk_idle_outputs("post");
    chk("post_ready", 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    int       beats;
    logic [DW-1:0] rd;
    logic [ND-1:0] rm;
    n_cmp = 0;
    n_err = 0;
    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_data_bus  = '0;
    bus.i_dest_mask = '0;
    bus.i_ready     = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_ready_low", 64'(bus.o_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 64'(bus.o_ready), 64'd1);
    @(negedge clk);

    // Single-destination packet
    run_packet(32'hA5A5_A5A5, 8'b0000_0001, 0);
    // Three destinations, no stalls
    run_packet(32'h1234_5678, 8'b1000_0101, 0);
    // Stall with first beat held four cycles
    run_packet(32'hDEAD_BEEF, 8'b0110_0000, 2);

    // Empty mask: accepted, dropped
    chk("zero_ready", 64'(bus.o_ready), 64'd1);
    bus.i_valid     = 1'b1;
    bus.i_data_bus  = 32'hCAFE_F00D;
    bus.i_dest_mask = 8'h00;
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk_idle_outputs("zero");
    @(negedge clk);
    chk_idle_outputs("zero2");
    chk("zero_ready2", 64'(bus.o_ready), 64'd1);

    // Reset during the 4th beat of a broadcast
    bus.i_valid     = 1'b1;
    bus.i_data_bus  = 32'h0F0F_0F0F;
    bus.i_dest_mask = 8'hFF;
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("ff_cmd",   64'(bus.o_cmd), 64'(b));
      chk("ff_valid", 64'(bus.o_valid), 64'd1);
      if (b == 3) rst = 1'b1;
      @(negedge clk);
    end
    chk_idle_outputs("midrst");
    rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.o_ready), 64'd1);
    @(negedge clk);
    chk_idle_outputs("midrst_after");
    run_packet(32'h5555_AAAA, 8'h10, 0);

    // Back-to-back packets with i_valid held high
    beats = 0;
    bus.i_valid     = 1'b1;
    bus.i_data_bus  = 32'h0000_0003;
    bus.i_dest_mask = 8'h03;
    @(negedge clk);
    chk("bb_cmd0",  64'(bus.o_cmd), 64'd0);
    chk("bb_last0", 64'(bus.o_last), 64'd0);
    beats += int'(bus.o_valid);
    bus.i_data_bus  = 32'h0000_0080;
    bus.i_dest_mask = 8'h80;
    @(negedge clk);
    chk("bb_cmd1",  64'(bus.o_cmd), 64'd1);
    chk("bb_last1", 64'(bus.o_last), 64'd1);
    beats += int'(bus.o_valid);
    @(negedge clk);
    chk("bb_bubble_valid", 64'(bus.o_valid), 64'd0);
    chk("bb_bubble_ready", 64'(bus.o_ready), 64'd1);
    beats += int'(bus.o_valid);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("bb_cmd7",  64'(bus.o_cmd), 64'd7);
    chk("bb_last7", 64'(bus.o_last), 64'd1);
    chk("bb_data7", 64'(bus.o_data_bus), 64'h80);
    beats += int'(bus.o_valid);
    @(negedge clk);
    beats += int'(bus.o_valid);
    chk("bb_beat_count", 64'(beats), 64'd3);
    chk_idle_outputs("bb_end");

    // Randomized packets with random back-pressure
    for (int p = 0; p < 30; p++) begin
      rd = $urandom;
      rm = 8'($urandom);
      run_packet(rd, rm, 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
